tx_window_arbiter: RTL and testbench

Sequences the spacecraft radio transmitter and shares it between on-board requesters (telemetry, payload downlink, beacon). It sits directly downstream of the orbit controller: it takes that block's transmit-window output as `tx_window`. On each window it powers the radio, waits for warm-up, and grants the transmitter to one requester at a time in round-robin order. It also enforces a per-grant time limit and an inter-grant guard gap.

---
 rtl/tx_window_arbiter.sv | 169 ++++++++++++++++
 tb/tb_tx_window_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_window_arbiter.sv
// Powers the radio on each transmit window and grants it round-robin with a grant time limit and a guard gap.
// Outputs are registered: request-to-grant is 1 cycle in IDLE; when the window closes, everything drops on the next edge.
module tx_window_arbiter #(
    parameter int NREQ          = 3,
    parameter int WARMUP_CYCLES = 20,
    parameter int MAX_GRANT     = 600,
    parameter int GUARD_CYCLES  = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tx_window,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         done,
    output logic                    radio_en,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_id,
    output logic                    busy,
    output logic                    abort,
    output logic                    timeout
);
    localparam int IW   = $clog2(NREQ);
    localparam int M1   = (WARMUP_CYCLES > MAX_GRANT) ? WARMUP_CYCLES : MAX_GRANT;
    localparam int CMAX = (M1 > GUARD_CYCLES) ? M1 : GUARD_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_WARMUP = 3'd1,
        ST_IDLE   = 3'd2,
        ST_GRANT  = 3'd3,
        ST_GUARD  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   gnt_id_q, gnt_id_d;
    logic            radio_en_q, radio_en_d;
    logic            busy_q, busy_d;
    logic            abort_q, abort_d;
    logic            timeout_q, timeout_d;

    logic            sel_found;
    logic [IW-1:0]   sel_idx;
    logic [IW-1:0]   ptr_nxt;
    logic [IW-1:0]   cand;
    logic            grant_end;

    // First requester at or above the pointer, wrapping modulo NREQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(ptr_q) + i) % NREQ);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign ptr_nxt   = (int'(sel_idx) == NREQ - 1) ? '0 : sel_idx + IW'(1);
    assign grant_end = done[gnt_id_q] || !req[gnt_id_q];

    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == CW'(CMAX)) ? cnt_q : cnt_q + CW'(1);
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        radio_en_d = radio_en_q;
        busy_d     = busy_q;
        abort_d    = 1'b0;
        timeout_d  = 1'b0;

        case (state_q)
            ST_OFF: begin
                radio_en_d = 1'b0;
                gnt_d      = '0;
                busy_d     = 1'b0;
                cnt_d      = '0;
                if (tx_window) begin
                    state_d    = ST_WARMUP;
                    radio_en_d = 1'b1;
                end
            end
            ST_WARMUP: begin
                radio_en_d = 1'b1;
                if (cnt_q == CW'(WARMUP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_IDLE: begin
                if (sel_found) begin
                    state_d  = ST_GRANT;
                    cnt_d    = '0;
                    gnt_d    = NREQ'(1) << sel_idx;
                    gnt_id_d = sel_idx;
                    busy_d   = 1'b1;
                    ptr_d    = ptr_nxt;
                end
            end
            ST_GRANT: begin
                // A finishing requester wins over a coincident time limit.
                if (grant_end || cnt_q == CW'(MAX_GRANT - 1)) begin
                    state_d   = ST_GUARD;
                    cnt_d     = '0;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    timeout_d = !grant_end;
                end
            end
            ST_GUARD: begin
                if (cnt_q == CW'(GUARD_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase

        if (state_q != ST_OFF && !tx_window) begin
            state_d    = ST_OFF;
            cnt_d      = '0;
            radio_en_d = 1'b0;
            gnt_d      = '0;
            busy_d     = 1'b0;
            timeout_d  = 1'b0;
            abort_d    = (state_q == ST_GRANT);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            ptr_q      <= '0;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            radio_en_q <= 1'b0;
            busy_q     <= 1'b0;
            abort_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            radio_en_q <= radio_en_d;
            busy_q     <= busy_d;
            abort_q    <= abort_d;
            timeout_q  <= timeout_d;
        end
    end

    assign radio_en = radio_en_q;
    assign gnt      = gnt_q;
    assign gnt_id   = gnt_id_q;
    assign busy     = busy_q;
    assign abort    = abort_q;
    assign timeout  = timeout_q;
endmodule

// File: tb/tb_tx_window_arbiter.sv
// Directed bench for tx_window_arbiter with default parameters (3 requesters, 20/600/5 cycles).
module tb_tx_window_arbiter;
    logic       clk;
    logic       reset;
    logic       tx_window;
    logic [2:0] req;
    logic [2:0] done;
    logic       radio_en;
    logic [2:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       abort;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    tx_window_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .tx_window (tx_window),
        .req       (req),
        .done      (done),
        .radio_en  (radio_en),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .abort     (abort),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle; inputs set afterwards are sampled on the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts zero-grant observations (the current one included) until a grant appears.
    task automatic wait_gnt(output int n);
        n = 1;
        tick();
        while (gnt == 3'b000 && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; tx_window = 1'b0; req = 3'b000; done = 3'b000;
        #12;
        checks++;
        if ({radio_en, gnt, gnt_id, busy, abort, timeout} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 000000000", {radio_en, gnt, gnt_id, busy, abort, timeout});
        end
        tick();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (radio_en !== 1'b0 || gnt !== 3'b000) begin
            errors++;
            $display("FAIL off_idle got radio_en=%b gnt=%b want 0 000", radio_en, gnt);
        end
    endtask

    task automatic test_warmup();
        req = 3'b001;
        tx_window = 1'b1;
        tick();
        checks++;
        if (radio_en !== 1'b1 || gnt !== 3'b000) begin
            errors++;
            $display("FAIL warmup_start got radio_en=%b gnt=%b want 1 000", radio_en, gnt);
        end
        repeat (20) tick();
        checks++;
        if (gnt !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL warmup_early_gnt got gnt=%b busy=%b want 000 0", gnt, busy);
        end
        tick();
        checks++;
        if (gnt !== 3'b001 || busy !== 1'b1 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL first_grant got gnt=%b busy=%b id=%0d want 001 1 0", gnt, busy, gnt_id);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] seq [4];
        int n;
        int bad;
        seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;
        req = 3'b111;
        for (int k = 0; k < 3; k++) begin
            bad = 0;
            repeat (49) begin
                tick();
                if (gnt !== seq[k]) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL rr_hold_%0d got %0d bad cycles want 0", k, bad);
            end
            done = seq[k];
            tick();
            done = 3'b000;
            checks++;
            if (gnt !== 3'b000 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rr_release_%0d got gnt=%b busy=%b want 000 0", k, gnt, busy);
            end
            wait_gnt(n);
            checks++;
            if (n != 6 || gnt !== seq[k+1]) begin
                errors++;
                $display("FAIL rr_next_%0d got gap=%0d gnt=%b want 6 %b", k, n, gnt, seq[k+1]);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        int hi;
        int pulses;
        req = 3'b010;
        wait_gnt(n);
        checks++;
        if (gnt !== 3'b010 || gnt_id !== 2'd1) begin
            errors++;
            $display("FAIL to_grant got gnt=%b id=%0d want 010 1", gnt, gnt_id);
        end
        hi = 1;
        pulses = 0;
        for (int i = 0; i < 700; i++) begin
            tick();
            if (timeout === 1'b1) pulses++;
            if (gnt !== 3'b010) break;
            hi++;
        end
        checks++;
        if (hi != 600 || timeout !== 1'b1 || pulses != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL to_length got hi=%0d timeout=%b pulses=%0d busy=%b want 600 1 1 0", hi, timeout, pulses, busy);
        end
        tick();
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_width got timeout=%b want 0", timeout);
        end
        wait_gnt(n);
        checks++;
        if (n != 5 || gnt !== 3'b010) begin
            errors++;
            $display("FAIL to_regrant got gap=%0d gnt=%b want 5 010", n, gnt);
        end
    endtask

    task automatic test_abort();
        int bad;
        repeat (99) tick();
        tx_window = 1'b0;
        tick();
        checks++;
        if (gnt !== 3'b000 || radio_en !== 1'b0 || busy !== 1'b0 || abort !== 1'b1) begin
            errors++;
            $display("FAIL abort_edge got gnt=%b radio_en=%b busy=%b abort=%b want 000 0 0 1", gnt, radio_en, busy, abort);
        end
        bad = 0;
        repeat (10) begin
            tick();
            if (abort !== 1'b0 || gnt !== 3'b000 || radio_en !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_quiet got %0d bad cycles want 0", bad);
        end
        tx_window = 1'b1;
        tick();
        repeat (20) tick();
        checks++;
        if (gnt !== 3'b000 || radio_en !== 1'b1) begin
            errors++;
            $display("FAIL reopen_warmup got gnt=%b radio_en=%b want 000 1", gnt, radio_en);
        end
        tick();
        checks++;
        if (gnt !== 3'b010) begin
            errors++;
            $display("FAIL reopen_grant got gnt=%b want 010", gnt);
        end
    endtask

    task automatic test_stray_done();
        int n;
        req = 3'b001;
        wait_gnt(n);
        checks++;
        if (gnt !== 3'b001) begin
            errors++;
            $display("FAIL sd_grant got gnt=%b want 001", gnt);
        end
        repeat (9) tick();
        done = 3'b100;
        tick();
        done = 3'b000;
        checks++;
        if (gnt !== 3'b001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stray_done got gnt=%b busy=%b want 001 1", gnt, busy);
        end
        repeat (589) tick();
        checks++;
        if (gnt !== 3'b001) begin
            errors++;
            $display("FAIL sd_last_cycle got gnt=%b want 001", gnt);
        end
        done = 3'b001;
        tick();
        done = 3'b000;
        checks++;
        if (gnt !== 3'b000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL done_vs_timeout got gnt=%b timeout=%b want 000 0", gnt, timeout);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        req = 3'b010;
        wait_gnt(n);
        checks++;
        if (gnt !== 3'b010) begin
            errors++;
            $display("FAIL rm_grant got gnt=%b want 010", gnt);
        end
        repeat (10) tick();
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({radio_en, gnt, gnt_id, busy, abort, timeout} !== 9'b0) begin
            errors++;
            $display("FAIL reset_mid_grant got %b want 000000000", {radio_en, gnt, gnt_id, busy, abort, timeout});
        end
        req = 3'b110;
        tick();
        reset = 1'b1;
        tick();
        repeat (4) tick();
        #3 reset = 1'b0;
        #1;
        checks++;
        if (radio_en !== 1'b0 || gnt !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_warmup got radio_en=%b gnt=%b want 0 000", radio_en, gnt);
        end
        tick();
        reset = 1'b1;
        tick();
        repeat (20) tick();
        checks++;
        if (gnt !== 3'b000) begin
            errors++;
            $display("FAIL rm_warmup got gnt=%b want 000", gnt);
        end
        tick();
        checks++;
        if (gnt !== 3'b010 || gnt_id !== 2'd1) begin
            errors++;
            $display("FAIL ptr_restart got gnt=%b id=%0d want 010 1", gnt, gnt_id);
        end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_round_robin();
        test_timeout();
        test_abort();
        test_stray_done();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
